// File: rtl/router_pkg.sv
// Shared router definitions: flit geometry, flit-type encodings and small
// helpers for pulling the type field out of a flit. The reductor and the
// egress queue both depend on these constants.
package router_pkg;

  localparam int FLIT_SIZE  = 32;
  localparam int HEADER_LEN = 2;

  typedef enum logic [HEADER_LEN-1:0] {
    HEAD_FLIT   = 2'b00,
    BODY_FLIT   = 2'b01,
    TAIL_FLIT   = 2'b10,
    SINGLE_FLIT = 2'b11
  } flit_type_t;

  // Push-side framing monitor state
  typedef enum logic {
    FRM_IDLE   = 1'b0,
    FRM_IN_PKT = 1'b1
  } frame_state_t;

  function automatic flit_type_t flit_type(input logic [FLIT_SIZE-1:0] flit);
    return flit_type_t'(flit[FLIT_SIZE-1 -: HEADER_LEN]);
  endfunction

  // TAIL and SINGLE both close a packet
  function automatic logic is_end_flit(input flit_type_t t);
    return (t == TAIL_FLIT) || (t == SINGLE_FLIT);
  endfunction

endpackage

// File: rtl/flit_fifo_ram.sv
// Flit storage array for the egress queue.
// Synchronous write, asynchronous (show-ahead) read, no reset on data.
// Ports:
//   clk    - clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data (combinational from raddr)
module flit_fifo_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/flit_egress_queue.sv
// Packet-aware flit FIFO sitting after the N-to-1 reductor.
// Takes flits from the reductor (in/in_valid, back-pressure via in_avail),
// presents them show-ahead on out/out_valid to the link (out_avail), and
// tracks how many complete packets are held. In store-and-forward mode a
// packet is only released once its end flit is stored, except when the
// queue fills with no complete packet (oversize packet), which forces a
// bypass until that packet's end flit leaves.
// Ports:
//   clk, rst_n     - clock, async active-low reset
//   in, in_valid   - flit from the reductor
//   in_avail       - queue can take a flit this cycle (not full)
//   out, out_valid - head-of-queue flit and release qualifier
//   out_avail      - downstream accepts out this cycle
//   occupancy      - flits stored
//   pkt_count      - complete packets (end flits) stored
//   frame_err      - sticky: a flit type arrived out of packet order
//   jumbo          - sticky: store-and-forward was bypassed
//
// Framing monitor states:
//   state      | meaning
//   FRM_IDLE   | between packets; HEAD or SINGLE expected
//   FRM_IN_PKT | inside a packet; BODY or TAIL expected
module flit_egress_queue
  import router_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter bit STORE_FWD = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [FLIT_SIZE-1:0]       in,
  input  logic                       in_valid,
  output logic                       in_avail,
  output logic [FLIT_SIZE-1:0]       out,
  output logic                       out_valid,
  input  logic                       out_avail,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [$clog2(DEPTH+1)-1:0] pkt_count,
  output logic                       frame_err,
  output logic                       jumbo
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [FLIT_SIZE-1:0] rdata;
  logic                 bypass;
  frame_state_t         frm_state;

  logic       push, pop, push_end, pop_end, bypass_set, not_empty;
  flit_type_t in_type, out_type;

  flit_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (FLIT_SIZE),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // in_avail is purely registered: a full queue stalls even if it pops now
  assign in_avail  = (occupancy != FULL);
  assign not_empty = (occupancy != '0);
  assign out_valid = not_empty & (!STORE_FWD | (pkt_count != '0) | bypass);
  // Stale RAM contents are hidden while empty so out reads 0 after reset
  assign out       = not_empty ? rdata : '0;

  assign push     = in_valid & in_avail;
  assign pop      = out_valid & out_avail;
  assign in_type  = flit_type(in);
  assign out_type = flit_type(rdata);
  assign push_end = push & is_end_flit(in_type);
  assign pop_end  = pop & is_end_flit(out_type);

  // Full with no complete packet can never drain in store-and-forward:
  // release the partial packet instead of deadlocking.
  assign bypass_set = STORE_FWD & (occupancy == FULL) & (pkt_count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      pkt_count <= '0;
      bypass    <= 1'b0;
      jumbo     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase

      case ({push_end, pop_end})
        2'b10:   pkt_count <= pkt_count + 1'b1;
        2'b01:   pkt_count <= pkt_count - 1'b1;
        default: pkt_count <= pkt_count;
      endcase

      // set and clear are exclusive: set needs no end flit in the queue
      if (bypass_set) begin
        bypass <= 1'b1;
        jumbo  <= 1'b1;
      end else if (pop_end) begin
        bypass <= 1'b0;
      end
    end
  end

  // Illegal types still get stored; the state follows the type itself
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_state <= FRM_IDLE;
      frame_err <= 1'b0;
    end else if (push) begin
      case (frm_state)
        FRM_IDLE: begin
          case (in_type)
            HEAD_FLIT:   frm_state <= FRM_IN_PKT;
            SINGLE_FLIT: frm_state <= FRM_IDLE;
            default:     frame_err <= 1'b1;
          endcase
        end
        FRM_IN_PKT: begin
          case (in_type)
            BODY_FLIT:   frm_state <= FRM_IN_PKT;
            TAIL_FLIT:   frm_state <= FRM_IDLE;
            HEAD_FLIT:   frame_err <= 1'b1;
            default: begin
              frame_err <= 1'b1;
              frm_state <= FRM_IDLE;
            end
          endcase
        end
        default: frm_state <= FRM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flit_egress_queue.sv
// Bench for flit_egress_queue: one cut-through and one store-and-forward
// instance, each followed every cycle by a queue-based reference model.
module tb_flit_egress_queue;
  import router_pkg::*;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int PW    = FLIT_SIZE - HEADER_LEN;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [FLIT_SIZE-1:0] in_s        [2];
  logic [FLIT_SIZE-1:0] out_s       [2];
  logic                 in_valid_s  [2];
  logic                 in_avail_s  [2];
  logic                 out_valid_s [2];
  logic                 out_avail_s [2];
  logic                 frame_err_s [2];
  logic                 jumbo_s     [2];
  logic [CW-1:0]        occ_s       [2];
  logic [CW-1:0]        pkt_s       [2];

  int checks   = 0;
  int failures = 0;

  function automatic void chk(input string name, input int d,
                              input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut%0d got=0x%0h expected=0x%0h at %0t",
               name, d, act, exp, $time);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    flit_egress_queue #(
      .DEPTH     (DEPTH),
      .STORE_FWD (g == 1)
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in        (in_s[g]),
      .in_valid  (in_valid_s[g]),
      .in_avail  (in_avail_s[g]),
      .out       (out_s[g]),
      .out_valid (out_valid_s[g]),
      .out_avail (out_avail_s[g]),
      .occupancy (occ_s[g]),
      .pkt_count (pkt_s[g]),
      .frame_err (frame_err_s[g]),
      .jumbo     (jumbo_s[g])
    );

    // Reference model: the queue itself is the scoreboard of expected flits
    logic [FLIT_SIZE-1:0]  mq [$];
    int                    m_pkt;
    bit                    m_bypass, m_inpkt, m_ferr, m_jumbo;
    int                    occ;
    bit                    exp_valid, exp_avail, push, pop, set_byp, legal;
    logic [FLIT_SIZE-1:0]  f;
    logic [HEADER_LEN-1:0] t;

    always @(negedge clk) begin
      if (!rst_n) begin
        mq.delete();
        m_pkt = 0; m_bypass = 0; m_inpkt = 0; m_ferr = 0; m_jumbo = 0;
      end
      occ       = mq.size();
      exp_valid = (occ != 0) && (g == 0 || m_pkt != 0 || m_bypass);
      exp_avail = (occ != DEPTH);
      chk("occupancy", g, occ_s[g], occ);
      chk("pkt_count", g, pkt_s[g], m_pkt);
      chk("out_valid", g, out_valid_s[g], exp_valid);
      chk("in_avail",  g, in_avail_s[g], exp_avail);
      chk("frame_err", g, frame_err_s[g], m_ferr);
      chk("jumbo",     g, jumbo_s[g], m_jumbo);
      if (rst_n) begin
        push    = in_valid_s[g] && exp_avail;
        pop     = exp_valid && out_avail_s[g];
        set_byp = (g == 1) && (occ == DEPTH) && (m_pkt == 0);
        if (pop) begin
          f = mq.pop_front();
          chk("out_flit", g, out_s[g], f);
          t = f[FLIT_SIZE-1 -: HEADER_LEN];
          if (t == TAIL_FLIT || t == SINGLE_FLIT) begin
            m_pkt--;
            m_bypass = 0;
          end
        end
        if (push) begin
          mq.push_back(in_s[g]);
          t = in_s[g][FLIT_SIZE-1 -: HEADER_LEN];
          if (t == TAIL_FLIT || t == SINGLE_FLIT) m_pkt++;
          legal = m_inpkt ? (t == BODY_FLIT || t == TAIL_FLIT)
                          : (t == HEAD_FLIT || t == SINGLE_FLIT);
          if (!legal) m_ferr = 1;
          m_inpkt = (t == HEAD_FLIT) || (t == BODY_FLIT && legal);
        end
        if (set_byp) begin
          m_bypass = 1;
          m_jumbo  = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Present one flit and hold it until the DUT accepts it
  task automatic send(input int d, input logic [HEADER_LEN-1:0] t,
                      output logic [FLIT_SIZE-1:0] flit);
    bit ok;
    int budget;
    flit = {t, PW'($urandom)};
    in_s[d] = flit;
    in_valid_s[d] = 1'b1;
    ok = 0;
    budget = 0;
    while (!ok && budget < 100) begin
      @(negedge clk);
      ok = in_avail_s[d];
      tick();
      budget++;
    end
    in_valid_s[d] = 1'b0;
    chk("send_accept", d, ok, 1);
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while (occ_s[d] != '0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain", d, occ_s[d], 0);
  endtask

  logic [FLIT_SIZE-1:0] fl;

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_s[d] = '0;
      in_valid_s[d] = 1'b0;
      out_avail_s[d] = 1'b0;
    end
    idle(2);
    chk("reset_out", 0, out_s[0], 0);
    rst_n = 1'b1;
    idle(1);

    // Cut-through packet
    out_avail_s[0] = 1'b1;
    send(0, HEAD_FLIT, fl);
    send(0, BODY_FLIT, fl);
    send(0, TAIL_FLIT, fl);
    drain(0);

    // Store-and-forward with a gap before the tail
    out_avail_s[1] = 1'b1;
    send(1, HEAD_FLIT, fl);
    send(1, BODY_FLIT, fl);
    send(1, BODY_FLIT, fl);
    idle(2);
    send(1, TAIL_FLIT, fl);
    drain(1);

    // Fill to full, then release while the source keeps pushing
    out_avail_s[0] = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(0, SINGLE_FLIT, fl);
    chk("full_in_avail", 0, in_avail_s[0], 0);
    chk("full_occ", 0, occ_s[0], DEPTH);
    chk("full_pkt", 0, pkt_s[0], DEPTH);
    out_avail_s[0] = 1'b1;
    for (int i = 0; i < 40 - DEPTH; i++) send(0, SINGLE_FLIT, fl);
    drain(0);

    // Oversize packet forces the bypass
    send(1, HEAD_FLIT, fl);
    for (int i = 0; i < 20; i++) send(1, BODY_FLIT, fl);
    chk("jumbo_set", 1, jumbo_s[1], 1);
    send(1, TAIL_FLIT, fl);
    drain(1);
    // bypass gone: a lone head is held back again
    send(1, HEAD_FLIT, fl);
    idle(3);
    chk("bypass_cleared", 1, out_valid_s[1], 0);
    chk("jumbo_sticky", 1, jumbo_s[1], 1);
    send(1, TAIL_FLIT, fl);
    drain(1);

    // Framing error: body while idle
    send(0, BODY_FLIT, fl);
    chk("frame_err_set", 0, frame_err_s[0], 1);
    send(0, SINGLE_FLIT, fl);
    drain(0);
    chk("frame_err_sticky", 0, frame_err_s[0], 1);

    // Async reset mid-packet
    out_avail_s[0] = 1'b0;
    send(0, HEAD_FLIT, fl);
    send(0, BODY_FLIT, fl);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_occ", 0, occ_s[0], 0);
    chk("arst_pkt", 0, pkt_s[0], 0);
    chk("arst_out_valid", 0, out_valid_s[0], 0);
    chk("arst_frame_err", 0, frame_err_s[0], 0);
    chk("arst_jumbo", 1, jumbo_s[1], 0);
    chk("arst_out", 0, out_s[0], 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    out_avail_s[0] = 1'b1;
    send(0, SINGLE_FLIT, fl);
    chk("post_reset_valid", 0, out_valid_s[0], 1);
    chk("post_reset_flit", 0, out_s[0], fl);
    drain(0);

    // Random traffic on both instances
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 400; c++) begin
        in_valid_s[d]  = ($urandom_range(0, 3) != 0);
        in_s[d]        = {HEADER_LEN'($urandom_range(0, 3)), PW'($urandom)};
        out_avail_s[d] = (c < 200) ? ($urandom_range(0, 3) == 0)
                                   : ($urandom_range(0, 2) != 0);
        tick();
      end
      in_valid_s[d]  = 1'b0;
      out_avail_s[d] = 1'b1;
      send(d, SINGLE_FLIT, fl);
      drain(d);
    end

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flit_egress_queue.md
Name: flit_egress_queue

Overview:
- Packet-aware flit FIFO placed directly downstream of the N-to-1 reductor.
- It consumes the reductor's out/out_valid and drives the reductor's out_avail.
- It feeds the link or output port through a valid/avail handshake.
- It supports cut-through or store-and-forward release, tracks complete packets held, and flags framing errors.

Parameters:
- DEPTH, 16: flit entries. Power of two, at least 4.
- STORE_FWD, 0: 0 releases flits in cut-through mode. 1 releases a packet only after its tail or single flit is stored.
- FLIT_SIZE: from the package. Flit width.
- HEADER_LEN: from the package. Width of the flit-type field at bits [FLIT_SIZE-1 -: HEADER_LEN].

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in  in  FLIT_SIZE  flit from the reductor's out.
- in_valid  in  1  reductor out_valid.
- in_avail  out  1  to the reductor's out_avail. 1 means a valid flit presented this cycle is taken.
- out  out  FLIT_SIZE  head-of-queue flit.
- out_valid  out  1  out holds a releasable flit.
- out_avail  in  1  downstream takes out this cycle when out_valid=1.
- occupancy  out  $clog2(DEPTH+1)  flits stored.
- pkt_count  out  $clog2(DEPTH+1)  complete packets stored, i.e. tail or single flits in the queue.
- frame_err  out  1  sticky framing-error flag.
- jumbo  out  1  sticky flag: store-and-forward bypassed for an oversize packet.

Behaviour:
- **Clock and reset:** one clock, clk. Reset is asynchronous and active-low on rst_n.
- **Reset values:** pointers=0, occupancy=0, pkt_count=0, out_valid=0, out=0, frame_err=0, jumbo=0, in_pkt (inside-packet state)=0. in_avail is 1 one cycle after reset deassertion.
- **Push:** push = in_valid & in_avail. Pop = out_valid & out_avail.
- **in_avail:** in_avail = (occupancy != DEPTH). It depends only on registered state, with no combinational path from out_avail, so a full queue stalls even when a pop occurs in the same cycle.
- **Storage:** circular RAM with read and write pointers of $clog2(DEPTH) bits each. Pointers wrap naturally. occupancy is updated +1 on push only, -1 on pop only, and is unchanged when both occur.
- **Output presentation:** show-ahead. out is the entry at the read pointer. A flit pushed into an empty queue appears on out the next cycle, giving a minimum latency of 1 clk.
- **Flit types:** the type field is compared against HEAD_FLIT, BODY_FLIT, TAIL_FLIT and SINGLE_FLIT. A push of TAIL or SINGLE is an end-flit push. A pop of TAIL or SINGLE is an end-flit pop.
- **pkt_count:** +1 on an end-flit push, -1 on an end-flit pop, net 0 when both occur in one cycle.
- **Release rule:**
  - STORE_FWD=0: out_valid = (occupancy != 0).
  - STORE_FWD=1: out_valid = (occupancy != 0) & (pkt_count != 0 | bypass).
  - bypass is a register. It is set when occupancy==DEPTH and pkt_count==0, which is the deadlock guard. jumbo is set at the same time. bypass is cleared on an end-flit pop.
- **Framing monitor (push side):**
  - States: IDLE (in_pkt=0) and IN_PKT (in_pkt=1).
  - IDLE + HEAD -> IN_PKT.
  - IDLE + SINGLE -> IDLE.
  - IN_PKT + BODY -> IN_PKT.
  - IN_PKT + TAIL -> IDLE.
  - Any other type on a push: frame_err is set (sticky until reset), the flit is still stored, and the state moves to the one the flit's type implies (HEAD -> IN_PKT, else IDLE).
- **Reset mid-packet:** all contents are discarded and all state returns to reset values. No flit is presented after reset until a new push.
- **Counter bounds:** occupancy and pkt_count never exceed DEPTH and never underflow. The verifier asserts both.

Decomposition:
- **Shared package** (router_pkg): FLIT_SIZE, HEADER_LEN, the HEAD_FLIT/BODY_FLIT/TAIL_FLIT/SINGLE_FLIT encodings, and a flit_type_t typedef. The reductor already relies on these constants.
- **Sub-module** flit_fifo_ram: a DEPTH x FLIT_SIZE storage array with synchronous write and asynchronous read, with no reset on data. The pointer, count, framing and release logic stay in flit_egress_queue.

Test Plan:
1. **Cut-through:** STORE_FWD=0, DEPTH=16, out_avail=1. Push HEAD, BODY, TAIL on consecutive cycles -> out_valid rises 1 cycle after the HEAD push, the 3 flits emerge in order, occupancy peaks at 1, pkt_count ends 0.
2. **Store-and-forward:** STORE_FWD=1. Push HEAD, BODY, BODY, then 2 idle cycles, then TAIL -> out_valid stays 0 until the cycle after the TAIL push, pkt_count=1, then 4 flits drain back-to-back and pkt_count returns to 0.
3. **Full back-pressure:** out_avail=0. Push 16 SINGLE flits -> in_avail=0 with occupancy=16 and pkt_count=16. Then set out_avail=1 while in_valid stays high -> no push on the first pop cycle, in_avail=1 one cycle later, and FIFO order is preserved across wrap (check 40 flits).
4. **Oversize packet:** STORE_FWD=1, DEPTH=16, out_avail=1. Push HEAD plus 20 BODY flits -> at occupancy=16, jumbo=1 and out_valid=1 the next cycle. Flits stream out, then the TAIL pop clears bypass while jumbo stays 1.
5. **Framing error:** push BODY in IDLE -> frame_err=1 the next cycle and the flit is still output. Then push SINGLE -> accepted, frame_err stays 1.
6. **Async reset mid-packet:** after pushing HEAD and BODY, pull rst_n low between clock edges -> occupancy, pkt_count, out_valid, frame_err and jumbo read 0 immediately. After release, a new SINGLE push is output 1 cycle later.
